// File: rtl/addsub_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addsub_serial : digit-serial signed/unsigned adder-subtractor            |
// |   DIGIT bits per clock, LSB digit first; optional clamp via SATURATE_EN  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
`ifdef SATURATE_EN
  logic             r_a_msb;
`endif

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_dig_full;
  logic [DIGIT-1:0] w_dig_sum;
  logic             w_dig_cout;
  logic             w_c_msb_in;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_next_sum;
  logic [WIDTH-1:0] w_final;

  assign in_ready = (r_state == S_IDLE) && !rst;

  // Operands are shifted right each digit, so the active digit is always at bit 0.
  assign w_a_dig    = r_a[DIGIT-1:0];
  assign w_b_dig    = r_b[DIGIT-1:0];
  assign w_dig_full = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  assign w_dig_sum  = w_dig_full[DIGIT-1:0];
  assign w_dig_cout = w_dig_full[DIGIT];
  // Carry into the digit MSB recovered from the MSB sum bit and its two inputs.
  assign w_c_msb_in = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_dig_sum[DIGIT-1];
  assign w_ovf      = w_c_msb_in ^ w_dig_cout;
  assign w_last     = (r_cnt == C_LAST);
  assign w_next_sum = WIDTH'({w_dig_sum, sum} >> DIGIT);

`ifdef SATURATE_EN
  assign w_final = !w_ovf  ? w_next_sum :
                   r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                             {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_final = w_next_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
`ifdef SATURATE_EN
      r_a_msb   <= 1'b0;
`endif
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
`ifdef SATURATE_EN
            r_a_msb <= a[WIDTH-1];
`endif
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_dig_cout;
          if (w_last) begin
            sum       <= w_final;
            cout      <= w_dig_cout;
            ovf       <= w_ovf;
            zero      <= (w_final == '0);
            out_valid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_DONE;
          end else begin
            sum   <= w_next_sum;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_addsub_serial : bench for addsub_serial at DIGIT = 1, 4, 8, 16        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_addsub_serial;

  logic              clk;
  logic              rst;
  logic [15:0]       a;
  logic [15:0]       b;
  logic              sub;
  logic              cin;
  logic [3:0]        in_valid_v;
  logic [3:0]        in_ready_v;
  logic [3:0]        out_valid_v;
  logic [3:0]        out_ready_v;
  logic [3:0][15:0]  sum_v;
  logic [3:0]        cout_v;
  logic [3:0]        ovf_v;
  logic [3:0]        zero_v;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [33:0] DIR [4] = '{
    {16'h1234, 16'h0FCD, 1'b0, 1'b0},
    {16'hFFFF, 16'h0001, 1'b0, 1'b0},
    {16'h8000, 16'h0001, 1'b1, 1'b0},
    {16'h7FFF, 16'h0001, 1'b0, 1'b0}
  };

  addsub_serial #(.WIDTH(16), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  addsub_serial #(.WIDTH(16), .DIGIT(8)) u_dut_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  addsub_serial #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ndig_of(input int k);
    case (k)
      0:       return 16;
      1:       return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the signed and unsigned readings of the operands.
  task automatic model(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic cv, output logic [15:0] es, output logic ec,
                       output logic eo, output logic ez);
    int sa, sb, r, ua, ub;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = int'(av);
    ub = int'(bv);
    r  = sv ? (sa - sb - int'(cv)) : (sa + sb + int'(cv));
    eo = (r > 32767) || (r < -32768);
    ec = sv ? (ua >= ub + int'(cv)) : (ua + ub + int'(cv) > 65535);
    es = r[15:0];
`ifdef SATURATE_EN
    if (eo) es = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    ez = (es == 16'h0000);
  endtask

  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic cv, input int hold);
    logic [15:0] es;
    logic        ec, eo, ez;
    int          lat, wn;
    model(av, bv, sv, cv, es, ec, eo, ez);
    wn = 0;
    while (!in_ready_v[k] && wn < 50) begin
      @(posedge clk); #1;
      wn++;
    end
    if (!in_ready_v[k]) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    a = av; b = bv; sub = sv; cin = cv;
    in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    // Operands scrambled after acceptance; valid is dropped.
    in_valid_v[k] = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    check("busy_rdy", {31'd0, in_ready_v[k]}, 32'd0);
    lat = 0;
    while (!out_valid_v[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ndig_of(k));
    check("sum", {16'd0, sum_v[k]}, {16'd0, es});
    check("cout", {31'd0, cout_v[k]}, {31'd0, ec});
    check("ovf", {31'd0, ovf_v[k]}, {31'd0, eo});
    check("zero", {31'd0, zero_v[k]}, {31'd0, ez});
    check("done_rdy", {31'd0, in_ready_v[k]}, 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid_v[k]}, 32'd1);
      check("hold_sum", {16'd0, sum_v[k]}, {16'd0, es});
      check("hold_rdy", {31'd0, in_ready_v[k]}, 32'd0);
    end
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    check("drain_valid", {31'd0, out_valid_v[k]}, 32'd0);
    check("drain_rdy", {31'd0, in_ready_v[k]}, 32'd1);
  endtask

  initial begin
    logic [33:0] dv;
    rst = 1'b1;
    in_valid_v = '0;
    out_ready_v = '0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {28'd0, out_valid_v}, 32'd0);
    check("rst_rdy", {28'd0, in_ready_v}, 32'd0);
    check("rst_sum", {16'd0, sum_v[1]}, 32'd0);
    check("rst_flags", {29'd0, cout_v[1], ovf_v[1], zero_v[1]}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_rdy", {28'd0, in_ready_v}, 32'hF);

    for (int i = 0; i < 4; i++) begin
      dv = DIR[i];
      run_op(1, dv[33:18], dv[17:2], dv[1], dv[0], (i == 0) ? 5 : 0);
    end
    for (int i = 0; i < 20; i++)
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));

    // Abort mid-operation: reset lands while digit 2 is in flight.
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
    in_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", {31'd0, out_valid_v[1]}, 32'd0);
    check("abort_rdy_rst", {31'd0, in_ready_v[1]}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_rdy", {31'd0, in_ready_v[1]}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_noresult", {31'd0, out_valid_v[1]}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        dv = DIR[i];
        run_op(k, dv[33:18], dv[17:2], dv[1], dv[0], 1);
      end
      for (int i = 0; i < 6; i++)
        run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
